// File: rtl/btn_sw_debounce_gen.sv
// btn_sw_debounce_gen: debouncer front-end for NBTN push-buttons and NSW slide switches.
// Every input bit goes through a 2-flop synchroniser and then a stability filter.
// All filters advance on one shared prescaler tick.
// Buttons also produce one-clk press and release strobes.
// Optional macro BTN_REPEAT_EN: adds auto-repeat press strobes while a button is held.

// One input channel: synchroniser, stability counter, debounced state, edge strobes
module btn_sw_debounce_lane #(
    parameter int STABLE_TICKS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic state,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(STABLE_TICKS) + 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

    // accept a new level only after STABLE_TICKS consecutive differing ticks;
    // the strobes are registered on the same edge as the state flip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (sync == state) begin
                    cnt <= '0;
                end else if (cnt == CW'(STABLE_TICKS - 1)) begin
                    state <= sync;
                    cnt   <= '0;
                    rise  <= sync;
                    fall  <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module btn_sw_debounce_gen #(
    parameter int NBTN         = 5,
    parameter int NSW          = 8,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] button,
    input  logic [NSW-1:0]  SW,
    output logic [NBTN-1:0] button_out,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NSW-1:0]  SW_OK,
    output logic            any_key
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // reject unsupported configurations at elaboration
    if (NBTN < 1 || NBTN > 32 || NSW < 1 || NSW > 32 || TICK_DIV < 2 ||
        STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
        $error("btn_sw_debounce_gen: parameter out of range");
    end

    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [NBTN-1:0] press_raw;
    logic [NSW-1:0]  sw_rise_unused;
    logic [NSW-1:0]  sw_fall_unused;

    assign tick = (pcnt == PW'(TICK_DIV - 1));

    // shared prescaler: one tick every TICK_DIV clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_sw_debounce_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .din  (button[i]),
            .state(button_out[i]),
            .rise (press_raw[i]),
            .fall (btn_release[i])
        );
    end

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        btn_sw_debounce_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .din  (SW[i]),
            .state(SW_OK[i]),
            .rise (sw_rise_unused[i]),
            .fall (sw_fall_unused[i])
        );
    end

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;

    for (genvar i = 0; i < NBTN; i++) begin : g_rpt
        logic [RW-1:0] rcnt;
        logic          rfirst;
        logic          rstb;

        // count held ticks; first repeat after REPEAT_DELAY, then every REPEAT_RATE.
        // Any edge or released state restarts the sequence from the long delay.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt   <= '0;
                rfirst <= 1'b0;
                rstb   <= 1'b0;
            end else begin
                rstb <= 1'b0;
                if (press_raw[i] || btn_release[i] || !button_out[i]) begin
                    rcnt   <= '0;
                    rfirst <= 1'b1;
                end else if (tick) begin
                    if (rcnt == (rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1))) begin
                        rstb   <= 1'b1;
                        rcnt   <= '0;
                        rfirst <= 1'b0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
            end
        end

        // a repeat landing on the release edge is masked by the cleared state
        assign btn_press[i] = press_raw[i] | (rstb & button_out[i]);
    end
`else
    assign btn_press = press_raw;
`endif

    // any_key is a registered OR, one clk behind button_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_key <= 1'b0;
        else        any_key <= |button_out;
    end
endmodule

// File: tb/tb_btn_sw_debounce_gen.sv
// Scoreboard bench for btn_sw_debounce_gen with TICK_DIV=4, STABLE_TICKS=3.
// Stimulus pushes expected strobes / switch-level changes; a negedge monitor pops and checks them.
module tb_btn_sw_debounce_gen;
    localparam int NBTN = 5;
    localparam int NSW  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NBTN-1:0] button = '0;
    logic [NSW-1:0]  SW = '0;
    logic [NBTN-1:0] button_out, btn_press, btn_release;
    logic [NSW-1:0]  SW_OK;
    logic            any_key;

    btn_sw_debounce_gen #(
        .NBTN(NBTN), .NSW(NSW), .TICK_DIV(4), .STABLE_TICKS(3),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .SW(SW),
        .button_out(button_out), .btn_press(btn_press), .btn_release(btn_release),
        .SW_OK(SW_OK), .any_key(any_key)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NBTN-1:0] press;
        logic [NBTN-1:0] rel;
        int              lo, hi, gap;
        logic            ak_b, ak_a;
    } bexp_t;
    typedef struct {
        logic [NSW-1:0] val;
        int             lo, hi;
    } sexp_t;

    bexp_t bq[$];
    sexp_t sq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_win(input string nm, input int c, input int lo, input int hi);
        checks++;
        if (c < lo || c > hi) begin
            errors++;
            $display("FAIL %s: at cycle %0d expected within %0d..%0d", nm, c, lo, hi);
        end
    endtask

    task automatic pushb(input logic [NBTN-1:0] p, input logic [NBTN-1:0] r,
                         input int lo, input int hi, input int gap,
                         input logic akb, input logic aka);
        bexp_t e;
        e.press = p; e.rel = r; e.lo = lo; e.hi = hi; e.gap = gap;
        e.ak_b = akb; e.ak_a = aka;
        bq.push_back(e);
    endtask

    task automatic pushs(input logic [NSW-1:0] v, input int lo, input int hi);
        sexp_t e;
        e.val = v; e.lo = lo; e.hi = hi;
        sq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: pops an expectation whenever a strobe or switch-level change appears
    initial begin
        bexp_t          be;
        sexp_t          se;
        logic [NSW-1:0] sw_prev = '0;
        logic           ak_pend = 1'b0;
        logic           ak_exp = 1'b0;
        int             last_press = 0;
        forever begin
            @(negedge clk);
            if (ak_pend) begin
                chk("any_key_after", any_key, ak_exp);
                ak_pend = 1'b0;
            end
            if (btn_press != '0 || btn_release != '0) begin
                if (bq.size() == 0) begin
                    chk("unexpected_strobe", {btn_press, btn_release}, '0);
                end else begin
                    be = bq.pop_front();
                    chk("press_mask", btn_press, be.press);
                    chk("release_mask", btn_release, be.rel);
                    chk_win("strobe_time", cyc, be.lo, be.hi);
                    if (be.gap != 0) chk_win("repeat_gap", cyc, last_press + be.gap, last_press + be.gap);
                    chk("any_key_before", any_key, be.ak_b);
                    ak_pend = 1'b1;
                    ak_exp  = be.ak_a;
                    if (btn_press != '0) last_press = cyc;
                end
            end
            if (SW_OK !== sw_prev) begin
                if (sq.size() == 0) begin
                    chk("unexpected_sw_ok", SW_OK, sw_prev);
                end else begin
                    se = sq.pop_front();
                    chk("sw_ok_value", SW_OK, se.val);
                    chk_win("sw_ok_time", cyc, se.lo, se.hi);
                end
                sw_prev = SW_OK;
            end
        end
    end

    // stimulus
    initial begin
        int k;
        rst_n = 1'b0; button = '0; SW = 8'hA5;
        step(3);
        chk("rst_button_out", button_out, '0);
        chk("rst_btn_press", btn_press, '0);
        chk("rst_btn_release", btn_release, '0);
        chk("rst_sw_ok", SW_OK, '0);
        chk("rst_any_key", any_key, 1'b0);

        // release reset with switches already at A5
        rst_n = 1'b1; k = cyc;
        pushs(8'hA5, k + 1, k + 14);
        step(20);

        // clean press/release on button 0
        button[0] = 1'b1; k = cyc;
        pushb(5'h01, 5'h00, k + 11, k + 14, 0, 1'b0, 1'b1);
        step(20);
        chk("b0_held", button_out, 5'h01);
        button[0] = 1'b0; k = cyc;
        pushb(5'h00, 5'h01, k + 11, k + 14, 0, 1'b1, 1'b0);
        step(20);

        // bouncing button 2: 12 toggles of 5 clk, then hold high
        for (int i = 0; i < 12; i++) begin
            button[2] = ~button[2];
            step(5);
        end
        chk("b2_no_bounce_accept", button_out, 5'h00);
        button[2] = 1'b1; k = cyc;
        pushb(5'h04, 5'h00, k + 11, k + 14, 0, 1'b0, 1'b1);
        step(20);
        chk("b2_held", button_out, 5'h04);
        button[2] = 1'b0; k = cyc;
        pushb(5'h00, 5'h04, k + 11, k + 14, 0, 1'b1, 1'b0);
        step(20);

        // button 1 hold then drop; any_key lag checked by the monitor
        button[1] = 1'b1; k = cyc;
        pushb(5'h02, 5'h00, k + 11, k + 14, 0, 1'b0, 1'b1);
        step(20);
        button[1] = 1'b0; k = cyc;
        pushb(5'h00, 5'h02, k + 11, k + 14, 0, 1'b1, 1'b0);
        step(20);

        // one-tick glitch on SW[0] must not change SW_OK
        SW = 8'hA4;
        step(4);
        SW = 8'hA5;
        step(20);
        chk("sw_glitch_reject", SW_OK, 8'hA5);
        SW = 8'h3C; k = cyc;
        pushs(8'h3C, k + 11, k + 14);
        step(20);

        // reset while button 0 is held: no release strobe, press re-qualifies
        button[0] = 1'b1; k = cyc;
        pushb(5'h01, 5'h00, k + 11, k + 14, 0, 1'b0, 1'b1);
        step(20);
        chk("b0_held_pre_rst", button_out, 5'h01);
        k = cyc;
        pushs(8'h00, k, k);
        rst_n = 1'b0;
        #1;
        chk("async_rst_button_out", button_out, 5'h00);
        chk("async_rst_any_key", any_key, 1'b0);
        step(3);
        rst_n = 1'b1; k = cyc;
        pushs(8'h3C, k + 1, k + 14);
        pushb(5'h01, 5'h00, k + 11, k + 14, 0, 1'b0, 1'b1);
        step(20);
        button[0] = 1'b0; k = cyc;
        pushb(5'h00, 5'h01, k + 11, k + 14, 0, 1'b1, 1'b0);
        step(20);

`ifdef BTN_REPEAT_EN
        // auto-repeat on button 3: press, +20 clk, then every 8 clk until release
        button[3] = 1'b1; k = cyc;
        pushb(5'h08, 5'h00, k + 11, k + 14, 0, 1'b0, 1'b1);
        pushb(5'h08, 5'h00, k + 31, k + 34, 20, 1'b1, 1'b1);
        pushb(5'h08, 5'h00, k + 39, k + 42, 8, 1'b1, 1'b1);
        pushb(5'h08, 5'h00, k + 47, k + 50, 8, 1'b1, 1'b1);
        pushb(5'h08, 5'h00, k + 55, k + 58, 8, 1'b1, 1'b1);
        step(50);
        button[3] = 1'b0; k = cyc;
        pushb(5'h00, 5'h08, k + 11, k + 14, 0, 1'b1, 1'b0);
        step(30);
`endif

        step(5);
        chk("strobes_outstanding", bq.size(), 0);
        chk("sw_changes_outstanding", sq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
